// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, FSM states and command opcodes for the SPI slave RAM block
package spi_pkg;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_SIZE = 8;
    localparam int DATA_W = 8;
    localparam logic [3:0] FRAME_BITS = 4'd10;
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;
    typedef enum logic [1:0] {IDLE, WRITE, READ_ADD, READ_DATA} state_t;
endpackage

// File: rtl/spi_ram.sv
// spi_ram: 256x8 single-port RAM decoding 10-bit opcode/payload commands
module spi_ram
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              rd_addr_seen
);
    logic [DATA_W-1:0] mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic tx_valid_q, tx_valid_d, rd_addr_seen_q, rd_addr_seen_d;
    logic [1:0] op;
    logic [DATA_W-1:0] payload;
    assign op = din[9:8];
    assign payload = din[7:0];
    assign dout = dout_q;
    assign tx_valid = tx_valid_q;
    assign rd_addr_seen = rd_addr_seen_q;
    always_comb begin
        wr_addr_d = (rx_valid && op == OP_WR_ADDR) ? payload : wr_addr_q;
        rd_addr_d = (rx_valid && op == OP_RD_ADDR) ? payload : rd_addr_q;
        dout_d = (rx_valid && op == OP_RD_DATA) ? mem[rd_addr_q] : dout_q;
        tx_valid_d = rx_valid && op == OP_RD_DATA;
        rd_addr_seen_d = !rx_valid ? rd_addr_seen_q :
                         op == OP_RD_ADDR ? 1'b1 :
                         op == OP_RD_DATA ? 1'b0 : rd_addr_seen_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            dout_q <= '0;
            tx_valid_q <= 1'b0;
            rd_addr_seen_q <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            dout_q <= dout_d;
            tx_valid_q <= tx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
        end
    end
    // contents survive reset so a preload or earlier writes stay visible
    always_ff @(posedge clk) begin
        if (rx_valid && op == OP_WR_DATA) mem[wr_addr_q] <= payload;
    end
endmodule

// File: rtl/spi_slave_wrapper.sv
// spi_slave_wrapper: SPI slave frame deserialiser and MISO serialiser in front of spi_ram
module spi_slave_wrapper
    import spi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d, bit_q, bit_d;
    logic done_q, done_d, rx_valid_q, rx_valid_d;
    logic go_q, go_d, miso_q, miso_d;
    logic [9:0] rx_data_q, rx_data_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d, tx_data, dout;
    logic tx_valid, rd_addr_seen;
    assign tx_data = tx_data_q;
    assign MISO = miso_q;
    spi_ram r1 (
        .clk(clk), .rst(rst), .din(rx_data_q), .rx_valid(rx_valid_q),
        .dout(dout), .tx_valid(tx_valid), .rd_addr_seen(rd_addr_seen)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        done_d = done_q;
        rx_data_d = rx_data_q;
        rx_valid_d = 1'b0;
        if (SS_n) begin
            state_d = IDLE;
            cnt_d = '0;
            done_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = !MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD;
        end else if (!done_q) begin
            rx_data_d = {rx_data_q[8:0], MOSI};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == FRAME_BITS - 4'd1) begin
                rx_valid_d = 1'b1;
                cnt_d = '0;
                done_d = 1'b1;
            end
        end
    end
    // readback shifts only while the master still holds the read-data frame open
    always_comb begin
        tx_data_d = tx_valid ? dout : tx_data_q;
        go_d = 1'b0;
        bit_d = '0;
        miso_d = 1'b0;
        if (tx_valid && !SS_n && state_q == READ_DATA) begin
            go_d = 1'b1;
        end else if (go_q && !SS_n && state_q == READ_DATA && bit_q < 4'd8) begin
            go_d = 1'b1;
            bit_d = bit_q + 4'd1;
            miso_d = tx_data_q[3'd7 - bit_q[2:0]];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            done_q <= 1'b0;
            rx_data_q <= '0;
            rx_valid_q <= 1'b0;
            tx_data_q <= '0;
            go_q <= 1'b0;
            bit_q <= '0;
            miso_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
            rx_data_q <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_data_q <= tx_data_d;
            go_q <= go_d;
            bit_q <= bit_d;
            miso_q <= miso_d;
        end
    end
endmodule

// File: tb/tb_spi_slave_wrapper.sv
// tb_spi_slave_wrapper: directed and randomised frame checks of the SPI slave RAM block
module tb_spi_slave_wrapper;
    import spi_pkg::*;
    logic clk = 1'b0, rst = 1'b1, SS_n = 1'b1, MOSI = 1'b0;
    logic MISO;
    int n_chk = 0, n_fail = 0;
    logic [13:0] win;
    spi_slave_wrapper dut (.clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic send_bits(input logic [10:0] f, input int n);
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            MOSI = f[10 - i];
            @(negedge clk);
        end
    endtask
    task automatic release_ss(input int n);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (n) @(negedge clk);
    endtask
    task automatic frame(input logic rw, input logic [1:0] op, input logic [7:0] pl);
        send_bits({rw, op, pl}, 11);
        release_ss(2);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask
    task automatic capture_miso();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            win[i] = MISO;
        end
    endtask
    initial begin
        int start;
        logic [7:0] got8, a, d;
        logic tail;
        do_reset();
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_tx_data", {24'd0, dut.tx_data}, 32'h00);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        frame(1'b0, 2'b00, 8'h3C);
        send_bits({1'b0, 2'b01, 8'hA5}, 11);
        release_ss(2);
        check("wr_mem_3c", {24'd0, dut.r1.mem[8'h3C]}, 32'hA5);
        frame(1'b1, 2'b10, 8'h3C);
        send_bits({1'b1, 2'b11, 8'h00}, 11);
        capture_miso();
        release_ss(2);
        check("rd_tx_data", {24'd0, dut.tx_data}, 32'hA5);
        start = -1;
        for (int i = 13; i >= 0; i--) if (win[i]) start = i;
        check("miso_started", {31'd0, start >= 0 && start <= 6}, 32'd1);
        if (start < 0 || start > 6) start = 6;
        for (int i = 0; i < 8; i++) got8[7 - i] = win[start + i];
        check("miso_bits", {24'd0, got8}, 32'hA5);
        tail = 1'b0;
        for (int i = start + 8; i < 14; i++) tail |= win[i];
        check("miso_tail_zero", {31'd0, tail}, 32'd0);
        check("miso_idle", {31'd0, MISO}, 32'd0);
        send_bits({1'b0, 2'b01, 8'hFF}, 5);
        release_ss(2);
        check("abort_no_rx_valid", {31'd0, dut.rx_valid_q}, 32'd0);
        check("abort_mem_kept", {24'd0, dut.r1.mem[8'h3C]}, 32'hA5);
        frame(1'b0, 2'b00, 8'h10);
        frame(1'b0, 2'b01, 8'h77);
        check("post_abort_mem_10", {24'd0, dut.r1.mem[8'h10]}, 32'h77);
        check("post_abort_mem_3c", {24'd0, dut.r1.mem[8'h3C]}, 32'hA5);
        do_reset();
        frame(1'b0, 2'b01, 8'h5A);
        check("mem0_written", {24'd0, dut.r1.mem[8'h00]}, 32'h5A);
        send_bits({1'b1, 2'b11, 8'h00}, 11);
        check("no_addr_state", 32'(dut.state_q), 32'(READ_ADD));
        capture_miso();
        release_ss(2);
        check("no_addr_tx_data", {24'd0, dut.tx_data}, 32'h5A);
        check("no_addr_miso_quiet", {18'd0, win}, 32'd0);
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            frame(1'b0, 2'b00, a);
            frame(1'b0, 2'b01, d);
            frame(1'b1, 2'b10, a);
            frame(1'b1, 2'b11, 8'($urandom));
            check("rand_readback", {24'd0, dut.tx_data}, {24'd0, d});
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
